// File: rtl/urv_mem_arbiter.sv
// Single-port RAM arbiter for urv_cpu: data port wins over fetch, with a
// starvation guard that forces a fetch slot after STARVE_LIMIT data grants.
// Each grant is answered exactly one cycle later, routed by the last-grant state.
module urv_mem_arbiter #(
  parameter int ADDR_BITS    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic [31:0]          im_addr_i,
  output logic [31:0]          im_data_o,
  output logic                 im_valid_o,
  input  logic [31:0]          dm_addr_i,
  input  logic [31:0]          dm_data_s_i,
  input  logic [3:0]           dm_data_select_i,
  input  logic                 dm_store_i,
  input  logic                 dm_load_i,
  output logic [31:0]          dm_data_l_o,
  output logic                 dm_ready_o,
  output logic                 dm_load_done_o,
  output logic                 dm_store_done_o,
  output logic                 ram_en_o,
  output logic [ADDR_BITS-3:0] ram_addr_o,
  output logic [3:0]           ram_we_o,
  output logic [31:0]          ram_wdata_o,
  input  logic [31:0]          ram_rdata_i
);

  localparam int CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {G_NONE, G_IM, G_DM_LD, G_DM_ST} grant_e;

  grant_e      last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] dm_data_l_q, dm_data_l_d;
  logic        trip, dm_gnt;

  // Byte-lane bits and the wrapped upper address bits carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dm_addr_i[31:ADDR_BITS], dm_addr_i[1:0]};

  assign trip   = (STARVE_LIMIT != 0) && (cnt_q == LIM);
  assign dm_gnt = (dm_store_i | dm_load_i) && !trip;

  // Grant decision, RAM request drive, next-state for counter/last-grant.
  always_comb begin
    last_d      = G_IM;
    cnt_d       = '0;
    im_addr_d   = im_addr_q;
    ram_en_o    = 1'b1;
    ram_we_o    = 4'b0;
    ram_wdata_o = 32'b0;
    ram_addr_o  = im_addr_i[ADDR_BITS-1:2];
    dm_ready_o  = !trip;
    if (dm_gnt) begin
      ram_addr_o = dm_addr_i[ADDR_BITS-1:2];
      cnt_d      = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
      // A store wins over a simultaneous load; the load is dropped.
      if (dm_store_i) begin
        last_d      = G_DM_ST;
        ram_we_o    = dm_data_select_i;
        ram_wdata_o = dm_data_s_i;
      end else begin
        last_d = G_DM_LD;
      end
    end else begin
      im_addr_d = im_addr_i;
    end
    // Hold every CPU/RAM-facing output quiet while in reset.
    if (!rst) begin
      ram_en_o    = 1'b0;
      ram_we_o    = 4'b0;
      ram_wdata_o = 32'b0;
      ram_addr_o  = '0;
      dm_ready_o  = 1'b0;
    end
  end

  // Response routing from the grant made in the previous cycle.
  always_comb begin
    im_data_o       = (last_q == G_IM) ? ram_rdata_i : 32'b0;
    im_valid_o      = (last_q == G_IM) && (im_addr_i == im_addr_q);
    dm_load_done_o  = (last_q == G_DM_LD);
    dm_store_done_o = (last_q == G_DM_ST);
    dm_data_l_o     = (last_q == G_DM_LD) ? ram_rdata_i : dm_data_l_q;
    dm_data_l_d     = dm_data_l_o;
  end

  // State registers; reset discards any in-flight response.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      last_q      <= G_NONE;
      cnt_q       <= '0;
      im_addr_q   <= 32'b0;
      dm_data_l_q <= 32'b0;
    end else begin
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      im_addr_q   <= im_addr_d;
      dm_data_l_q <= dm_data_l_d;
    end
  end

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter with a behavioural RAM and a response scoreboard.
module tb_urv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [31:0] im_addr_i, dm_addr_i, dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i, dm_load_i;
  logic [31:0] im_data_o, dm_data_l_o, ram_wdata_o;
  logic        im_valid_o, dm_ready_o, dm_load_done_o, dm_store_done_o, ram_en_o;
  logic [13:0] ram_addr_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_rdata_i;

  // Guard-disabled instance, only its ready is observed.
  logic [31:0] z_unused_imd, z_unused_dml, z_unused_wd;
  logic        z_unused_imv, z_ready, z_unused_ld, z_unused_sd, z_unused_en;
  logic [13:0] z_unused_addr;
  logic [3:0]  z_unused_we;

  always #5 clk_i = ~clk_i;

  urv_mem_arbiter #(.ADDR_BITS(16), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst(rst), .im_addr_i(im_addr_i), .im_data_o(im_data_o),
    .im_valid_o(im_valid_o), .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(dm_data_l_o), .dm_ready_o(dm_ready_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i));

  urv_mem_arbiter #(.ADDR_BITS(16), .STARVE_LIMIT(0)) dut_nolim (
    .clk_i(clk_i), .rst(rst), .im_addr_i(im_addr_i), .im_data_o(z_unused_imd),
    .im_valid_o(z_unused_imv), .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(z_unused_dml), .dm_ready_o(z_ready), .dm_load_done_o(z_unused_ld),
    .dm_store_done_o(z_unused_sd), .ram_en_o(z_unused_en), .ram_addr_o(z_unused_addr),
    .ram_we_o(z_unused_we), .ram_wdata_o(z_unused_wd), .ram_rdata_i(32'h0));

  function automatic logic [31:0] init_val(input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h11:    return 32'hCAFEF00D;
      'h20:    return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  // Synchronous single-port RAM, read-before-write, preloaded on first edge.
  logic [31:0] mem [0:16383];
  logic        mem_ready = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= mem[ram_addr_o];
    end
  end

  typedef enum {R_NONE, R_IM, R_LD, R_ST} rk_e;
  typedef struct {rk_e k; logic [31:0] addr; logic [31:0] data;} rsp_t;
  rsp_t        sbq[$];
  logic [31:0] shadow [0:16383];
  logic [31:0] ld_hold;
  int          cnt_m, nstall;
  int          ntests = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_im_data", im_data_o, 0);
    chk("rst_im_valid", im_valid_o, 0);
    chk("rst_dm_data", dm_data_l_o, 0);
    chk("rst_ready", dm_ready_o, 0);
    chk("rst_ld_done", dm_load_done_o, 0);
    chk("rst_st_done", dm_store_done_o, 0);
    chk("rst_ram_en", ram_en_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_wdata", ram_wdata_o, 0);
  endtask

  // One cycle: drive, check last cycle's response, check this grant, push expectation.
  task automatic cyc(input logic ld, input logic st, input logic [31:0] da,
                     input logic [31:0] ds, input logic [3:0] sel, input logic [31:0] ia);
    rsp_t r;
    logic trip, dmg;
    logic [13:0] w;
    dm_load_i = ld; dm_store_i = st; dm_addr_i = da; dm_data_s_i = ds;
    dm_data_select_i = sel; im_addr_i = ia;
    #1;
    if (sbq.size() > 0) r = sbq.pop_front();
    else begin r.k = R_NONE; r.addr = 0; r.data = 0; end
    chk("im_valid", im_valid_o, (r.k == R_IM) && (r.addr == ia));
    chk("ld_done", dm_load_done_o, r.k == R_LD);
    chk("st_done", dm_store_done_o, r.k == R_ST);
    if (r.k == R_IM) chk("im_data", im_data_o, r.data);
    if (r.k == R_LD) ld_hold = r.data;
    chk("ld_data", dm_data_l_o, ld_hold);
    trip = (cnt_m == 4);
    dmg  = (ld | st) && !trip;
    if (trip) nstall++;
    chk("ready", dm_ready_o, !trip);
    chk("ready_nolim", z_ready, 1);
    chk("ram_en", ram_en_o, 1);
    w = dmg ? da[15:2] : ia[15:2];
    chk("ram_addr", ram_addr_o, w);
    chk("ram_we", ram_we_o, (dmg && st) ? sel : 4'b0);
    if (dmg && st) begin
      chk("ram_wdata", ram_wdata_o, ds);
      r.k = R_ST; r.addr = da; r.data = 0;
      for (int b = 0; b < 4; b++) if (sel[b]) shadow[w][8*b +: 8] = ds[8*b +: 8];
      cnt_m = (cnt_m == 4) ? 4 : cnt_m + 1;
    end else if (dmg) begin
      r.k = R_LD; r.addr = da; r.data = shadow[w];
      cnt_m = (cnt_m == 4) ? 4 : cnt_m + 1;
    end else begin
      r.k = R_IM; r.addr = ia; r.data = shadow[w];
      cnt_m = 0;
    end
    sbq.push_back(r);
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input logic [31:0] ia);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ia);
  endtask

  task automatic load(input logic [31:0] da, input logic [31:0] ia);
    cyc(1'b1, 1'b0, da, 32'h0, 4'h0, ia);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) shadow[i] = init_val(i);
    ld_hold = 0; cnt_m = 0; nstall = 0;
    rst = 1'b0; im_addr_i = 0; dm_addr_i = 0; dm_data_s_i = 0;
    dm_data_select_i = 0; dm_store_i = 0; dm_load_i = 0;
    #1 chk_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst = 1'b1;

    // Fetch only
    repeat (4) idle(32'h40);
    // Load priority over pending fetch
    load(32'h80, 32'h40);
    idle(32'h40);
    chk("load_value", dm_data_l_o, 32'h12345678);
    // Stale fetch
    idle(32'h40);
    idle(32'h44);
    idle(32'h44);
    idle(32'h44);
    // Byte store then readback
    cyc(1'b0, 1'b1, 32'h84, 32'hAABBCCDD, 4'b0100, 32'h44);
    load(32'h84, 32'h44);
    idle(32'h44);
    chk("byte_store", dm_data_l_o, 32'h00BB0000);
    // Simultaneous load+store, then zero-select store
    cyc(1'b1, 1'b1, 32'h88, 32'h55667788, 4'hF, 32'h40);
    load(32'h88, 32'h40);
    cyc(1'b0, 1'b1, 32'h88, 32'hFFFFFFFF, 4'h0, 32'h40);
    load(32'h88, 32'h40);
    idle(32'h40);
    chk("ldst_value", dm_data_l_o, 32'h55667788);
    // Starvation: 4 data grants then one forced fetch
    nstall = 0;
    repeat (10) load(32'h80, 32'h40);
    idle(32'h40);
    chk("starve_stalls", nstall, 2);
    // Address wrap above ADDR_BITS
    load(32'h0001_0080, 32'h0001_0040);
    idle(32'h0001_0040);
    idle(32'h0001_0040);
    // Reset mid-load with the counter part-way up
    repeat (3) load(32'h80, 32'h40);
    dm_load_i = 1'b1;
    rst = 1'b0;
    #1 chk_reset();
    sbq.delete(); cnt_m = 0; ld_hold = 0;
    @(posedge clk_i); #1;
    chk_reset();
    rst = 1'b1;
    idle(32'h40);
    repeat (5) load(32'h80, 32'h40);
    idle(32'h40);
    idle(32'h40);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
